// File: rtl/trigger_issue_unit_pkg.sv
// Shared constants and types for the trigger issue unit.
// The trigger mask keeps the "must be true" half in the upper bits and the "must be false" half below it.
package trigger_issue_unit_pkg;

   localparam int unsigned TIA_NUM_INSTRUCTIONS        = 16;
   localparam int unsigned TIA_INSTRUCTION_INDEX_WIDTH = $clog2(TIA_NUM_INSTRUCTIONS);
   localparam int unsigned TIA_NUM_PREDICATES          = 8;
   localparam int unsigned TIA_PTM_WIDTH               = 2 * TIA_NUM_PREDICATES;
   localparam int unsigned TIA_NUM_INPUT_CHANNELS      = 4;
   localparam int unsigned TIA_STALL_COUNT_WIDTH       = 16;

   typedef logic [TIA_NUM_PREDICATES-1:0]          pred_t;
   typedef logic [TIA_NUM_INPUT_CHANNELS-1:0]      chan_t;
   typedef logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] index_t;

   typedef struct packed {
      pred_t ptm_true;
      pred_t ptm_false;
   } ptm_t;

endpackage

// File: rtl/trigger_issue_unit_if.sv
// Issue handshake towards the pipeline and retire notifications from the predicate unit.
interface trigger_issue_unit_if;
   import trigger_issue_unit_pkg::*;

   logic   issue_valid;
   index_t issue_index;
   logic   issue_ready;
   logic   retire_valid;
   pred_t  retire_predicate_mask;

   modport master (
      output issue_valid,
      output issue_index,
      input  issue_ready,
      input  retire_valid,
      input  retire_predicate_mask
   );

   modport slave (
      input  issue_valid,
      input  issue_index,
      output issue_ready,
      output retire_valid,
      output retire_predicate_mask
   );

endinterface

// File: rtl/trigger_issue_unit_priority_encoder.sv
// Lowest-set-bit priority encoder with an any-set flag.
module priority_encoder #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned INDEX_WIDTH = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]       req,
   output logic [INDEX_WIDTH-1:0] index,
   output logic                   any
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      index = '0;
      any   = 1'b0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (req[i]) begin
            index = INDEX_WIDTH'(i);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/trigger_issue_unit.sv
// Evaluates instruction triggers against predicates, channel readiness and the predicate
// scoreboard, and issues the lowest triggered slot through a valid/ready register.
module trigger_issue_unit
   import trigger_issue_unit_pkg::*;
#(
   parameter int unsigned STALL_COUNT_WIDTH = TIA_STALL_COUNT_WIDTH
) (
   input  logic                                                 clock,
   input  logic                                                 reset,
   input  logic                                                 enable,
   input  pred_t                                                predicates,
   input  logic [TIA_NUM_INSTRUCTIONS-1:0]                      instruction_valid,
   input  logic [TIA_NUM_INSTRUCTIONS-1:0][TIA_PTM_WIDTH-1:0]   instruction_ptm,
   input  logic [TIA_NUM_INSTRUCTIONS-1:0][TIA_NUM_INPUT_CHANNELS-1:0] instruction_icm,
   input  logic [TIA_NUM_INSTRUCTIONS-1:0][TIA_NUM_PREDICATES-1:0]     instruction_pwm,
   input  chan_t                                                input_channels_ready,
   trigger_issue_unit_if.master                                 iss,
   output pred_t                                                pending_predicates,
   output logic [STALL_COUNT_WIDTH-1:0]                         stall_count
);

   localparam int unsigned NI = TIA_NUM_INSTRUCTIONS;
   localparam int unsigned SW = STALL_COUNT_WIDTH;

   logic          valid_q, valid_d;
   index_t        index_q, index_d;
   pred_t         pending_q, pending_d;
   logic [SW-1:0] stall_q, stall_d;

   pred_t         eff_pending;
   logic [NI-1:0] triggered;
   index_t        winner;
   logic          any_triggered;
   logic          slot_open;

   // Retirement clears pending bits in time for this cycle's trigger evaluation.
   assign eff_pending = pending_q & ~(iss.retire_valid ? iss.retire_predicate_mask : '0);

   for (genvar g = 0; g < int'(NI); g++) begin : g_trig
      ptm_t  ptm;
      pred_t reads;
      assign ptm   = ptm_t'(instruction_ptm[g]);
      assign reads = ptm.ptm_true | ptm.ptm_false;
      assign triggered[g] = instruction_valid[g]
                          && ((predicates & ptm.ptm_true) == ptm.ptm_true)
                          && ((~predicates & ptm.ptm_false) == ptm.ptm_false)
                          && ((input_channels_ready & instruction_icm[g]) == instruction_icm[g])
                          && ((reads & eff_pending) == '0)
                          && ((instruction_pwm[g] & eff_pending) == '0);
   end

   priority_encoder #(
      .WIDTH       (NI),
      .INDEX_WIDTH (TIA_INSTRUCTION_INDEX_WIDTH)
   ) u_winner (
      .req   (triggered),
      .index (winner),
      .any   (any_triggered)
   );

   // Next-state for issue register, scoreboard and stall counter.
   always_comb begin
      valid_d   = valid_q;
      index_d   = index_q;
      pending_d = eff_pending;
      stall_d   = stall_q;
      slot_open = !valid_q || iss.issue_ready;

      if (enable && slot_open && any_triggered) begin
         valid_d   = 1'b1;
         index_d   = winner;
         pending_d = eff_pending | instruction_pwm[winner];
      end else if (iss.issue_ready) begin
         valid_d   = 1'b0;
      end

      if (enable && slot_open && !any_triggered && (stall_q != '1)) begin
         stall_d = stall_q + SW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         index_q   <= '0;
         pending_q <= '0;
         stall_q   <= '0;
      end else begin
         valid_q   <= valid_d;
         index_q   <= index_d;
         pending_q <= pending_d;
         stall_q   <= stall_d;
      end
   end

   assign iss.issue_valid    = valid_q;
   assign iss.issue_index    = index_q;
   assign pending_predicates = pending_q;
   assign stall_count        = stall_q;

endmodule

// File: tb/tb_trigger_issue_unit.sv
// Directed bench for trigger_issue_unit: priority, backpressure, scoreboard, stall saturation, reset.
module tb_trigger_issue_unit;
   import trigger_issue_unit_pkg::*;

   localparam int unsigned SW = 4;

   logic                    clock;
   logic                    reset;
   logic                    enable;
   logic [7:0]              predicates;
   logic [15:0]             instruction_valid;
   logic [15:0][15:0]       instruction_ptm;
   logic [15:0][3:0]        instruction_icm;
   logic [15:0][7:0]        instruction_pwm;
   logic [3:0]              input_channels_ready;
   logic [7:0]              pending_predicates;
   logic [SW-1:0]           stall_count;

   int n_cmp;
   int n_err;

   trigger_issue_unit_if tif ();

   trigger_issue_unit #(.STALL_COUNT_WIDTH(SW)) dut (
      .clock                (clock),
      .reset                (reset),
      .enable               (enable),
      .predicates           (predicates),
      .instruction_valid    (instruction_valid),
      .instruction_ptm      (instruction_ptm),
      .instruction_icm      (instruction_icm),
      .instruction_pwm      (instruction_pwm),
      .input_channels_ready (input_channels_ready),
      .iss                  (tif),
      .pending_predicates   (pending_predicates),
      .stall_count          (stall_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic set_slot(input int i, input logic v, input logic [7:0] t, input logic [7:0] f,
                           input logic [3:0] c, input logic [7:0] w);
      instruction_valid[i] = v;
      instruction_ptm[i]   = {t, f};
      instruction_icm[i]   = c;
      instruction_pwm[i]   = w;
   endtask

   task automatic clear_slots();
      instruction_valid = '0;
      instruction_ptm   = '0;
      instruction_icm   = '0;
      instruction_pwm   = '0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      enable = 1'b0;
      predicates = '0;
      input_channels_ready = '0;
      tif.issue_ready = 1'b0;
      tif.retire_valid = 1'b0;
      tif.retire_predicate_mask = '0;
      clear_slots();

      // Reset state
      tick(2);
      check("rst_valid", 32'(tif.issue_valid), 32'h0);
      check("rst_index", 32'(tif.issue_index), 32'h0);
      check("rst_pending", 32'(pending_predicates), 32'h0);
      check("rst_stall", 32'(stall_count), 32'h0);
      reset = 1'b1;

      // Priority: slots 2 and 5 both need p0
      enable = 1'b1;
      tif.issue_ready = 1'b1;
      predicates = 8'h01;
      set_slot(2, 1'b1, 8'h01, 8'h00, 4'h0, 8'h00);
      set_slot(5, 1'b1, 8'h01, 8'h00, 4'h0, 8'h00);
      tick(1);
      check("prio_valid", 32'(tif.issue_valid), 32'h1);
      check("prio_index2", 32'(tif.issue_index), 32'h2);
      set_slot(2, 1'b0, 8'h01, 8'h00, 4'h0, 8'h00);
      tick(1);
      check("prio_index5", 32'(tif.issue_index), 32'h5);
      predicates = 8'h00;
      tick(1);
      check("prio_drop_valid", 32'(tif.issue_valid), 32'h0);

      // Backpressure: lower slot appears while stalled, only taken after ready
      predicates = 8'h01;
      tif.issue_ready = 1'b0;
      tick(1);
      check("bp_first_index", 32'(tif.issue_index), 32'h5);
      set_slot(3, 1'b1, 8'h01, 8'h00, 4'h0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         tick(1);
         check("bp_hold_valid", 32'(tif.issue_valid), 32'h1);
         check("bp_hold_index", 32'(tif.issue_index), 32'h5);
      end
      tif.issue_ready = 1'b1;
      tick(1);
      check("bp_release_index", 32'(tif.issue_index), 32'h3);
      clear_slots();
      tick(1);
      check("bp_drain_valid", 32'(tif.issue_valid), 32'h0);

      // Predicate-false mask and input channel requirement
      predicates = 8'h02;
      input_channels_ready = 4'h2;
      set_slot(6, 1'b1, 8'h00, 8'h02, 4'h2, 8'h00);
      tick(1);
      check("pfalse_block", 32'(tif.issue_valid), 32'h0);
      predicates = 8'h00;
      tick(1);
      check("pfalse_issue_valid", 32'(tif.issue_valid), 32'h1);
      check("pfalse_issue_index", 32'(tif.issue_index), 32'h6);
      input_channels_ready = 4'h0;
      tick(1);
      check("chan_block", 32'(tif.issue_valid), 32'h0);

      // Scoreboard: slot 0 writes p2, slot 1 reads p2
      clear_slots();
      predicates = 8'h05;
      set_slot(0, 1'b1, 8'h00, 8'h00, 4'h0, 8'h04);
      set_slot(1, 1'b1, 8'h04, 8'h00, 4'h0, 8'h00);
      tick(1);
      check("sb_index0", 32'(tif.issue_index), 32'h0);
      check("sb_pending_set", 32'(pending_predicates), 32'h04);
      set_slot(0, 1'b0, 8'h00, 8'h00, 4'h0, 8'h04);
      tick(1);
      check("sb_blocked_valid", 32'(tif.issue_valid), 32'h0);
      check("sb_blocked_pending", 32'(pending_predicates), 32'h04);
      tif.retire_valid = 1'b1;
      tif.retire_predicate_mask = 8'h04;
      tick(1);
      check("sb_bypass_valid", 32'(tif.issue_valid), 32'h1);
      check("sb_bypass_index", 32'(tif.issue_index), 32'h1);
      check("sb_bypass_pending", 32'(pending_predicates), 32'h00);
      tif.retire_valid = 1'b0;

      // Same-edge set and clear of p3: set wins
      clear_slots();
      set_slot(4, 1'b1, 8'h00, 8'h00, 4'h0, 8'h08);
      tick(1);
      check("sc_pending_first", 32'(pending_predicates), 32'h08);
      tif.retire_valid = 1'b1;
      tif.retire_predicate_mask = 8'h08;
      tick(1);
      check("sc_index", 32'(tif.issue_index), 32'h4);
      check("sc_pending_setwins", 32'(pending_predicates), 32'h08);
      clear_slots();
      tif.retire_predicate_mask = 8'h10;
      tick(1);
      check("sc_retire_nonpending", 32'(pending_predicates), 32'h08);
      tif.retire_predicate_mask = 8'h08;
      tick(1);
      check("sc_retire_clear", 32'(pending_predicates), 32'h00);
      tif.retire_valid = 1'b0;
      tif.retire_predicate_mask = 8'h00;

      // Asynchronous reset while a handshake is held
      set_slot(7, 1'b1, 8'h00, 8'h00, 4'h0, 8'hFF);
      tif.issue_ready = 1'b0;
      tick(1);
      check("ar_pre_pending", 32'(pending_predicates), 32'hFF);
      check("ar_pre_valid", 32'(tif.issue_valid), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check("ar_valid", 32'(tif.issue_valid), 32'h0);
      check("ar_index", 32'(tif.issue_index), 32'h0);
      check("ar_pending", 32'(pending_predicates), 32'h00);
      check("ar_stall", 32'(stall_count), 32'h0);
      #1;
      reset = 1'b1;
      tif.issue_ready = 1'b1;
      tick(1);
      check("ar_first_valid", 32'(tif.issue_valid), 32'h1);
      check("ar_first_index", 32'(tif.issue_index), 32'h7);
      check("ar_first_pending", 32'(pending_predicates), 32'hFF);
      check("ar_first_stall", 32'(stall_count), 32'h0);

      // Stall counter saturation and enable gating
      clear_slots();
      enable = 1'b0;
      reset = 1'b0;
      #1;
      reset = 1'b1;
      tick(3);
      check("st_disabled", 32'(stall_count), 32'h0);
      enable = 1'b1;
      tick(10);
      check("st_count10", 32'(stall_count), 32'd10);
      tick(10);
      check("st_saturated", 32'(stall_count), 32'd15);
      enable = 1'b0;
      tick(5);
      check("st_held", 32'(stall_count), 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
